// File: rtl/mfifo_arb_pkg.sv
// rtl/mfifo_arb_pkg.sv - shared types for the multi-requester FIFO write arbiter
package mfifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mfifo_rr_pick.sv
// rtl/mfifo_rr_pick.sv - first set request at or after a start index, wrapping
module mfifo_rr_pick #(
    parameter int REQ_NUM = 4,
    parameter int ID_W    = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    int j;

    // Walk offsets from the far end so the smallest offset from start wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        j     = 0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            j = int'(start) + i;
            if (j >= REQ_NUM) begin
                j = j - REQ_NUM;
            end
            if (req[j[ID_W-1:0]]) begin
                found = 1'b1;
                index = j[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mfifo_wr_arbiter.sv
// rtl/mfifo_wr_arbiter.sv - packet-locked round-robin write arbiter into one FIFO
module mfifo_wr_arbiter
    import mfifo_arb_pkg::*;
#(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [REQ_NUM-1:0]                  req_valid_i,
    input  logic [REQ_NUM-1:0]                  req_last_i,
    input  logic [REQ_NUM-1:0][DATA_WIDTH-1:0]  req_data_i,
    output logic [REQ_NUM-1:0]                  req_ready_o,
    input  logic                                full_i,
    output logic                                wren_o,
    output logic [DATA_WIDTH-1:0]               wdata_o,
    output logic                                grant_valid_o,
    output logic [$clog2(REQ_NUM)-1:0]          grant_id_o
);

    localparam int ID_W = $clog2(REQ_NUM);

    arb_state_t      state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] lock_id;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic            gnt_v;
    logic [ID_W-1:0] gnt_id;
    logic            xfer;
    logic            xfer_last;
    logic [ID_W-1:0] gnt_next;

    mfifo_rr_pick #(
        .REQ_NUM (REQ_NUM),
        .ID_W    (ID_W)
    ) u_pick (
        .req   (req_valid_i),
        .start (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // In LOCK the owner keeps the grant even while its valid is low.
    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = rr_ptr;
        if (state == ST_LOCK) begin
            gnt_v  = 1'b1;
            gnt_id = lock_id;
        end else if (pick_found) begin
            gnt_v  = 1'b1;
            gnt_id = pick_idx;
        end
    end

    assign xfer      = gnt_v && req_valid_i[gnt_id] && !full_i;
    assign xfer_last = xfer && req_last_i[gnt_id];
    assign gnt_next  = (gnt_id == ID_W'(REQ_NUM - 1)) ? '0 : gnt_id + ID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            if (xfer_last) begin
                state  <= ST_IDLE;
                rr_ptr <= gnt_next;
            end else if (state == ST_IDLE && gnt_v) begin
                state   <= ST_LOCK;
                lock_id <= gnt_id;
            end
        end
    end

    // Outputs are forced low combinationally so reset takes effect without a clock.
    always_comb begin
        req_ready_o   = '0;
        wren_o        = 1'b0;
        wdata_o       = '0;
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        if (rst_n) begin
            grant_valid_o = gnt_v;
            grant_id_o    = gnt_id;
            if (xfer) begin
                wren_o              = 1'b1;
                wdata_o             = req_data_i[gnt_id];
                req_ready_o[gnt_id] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mfifo_wr_arbiter.sv
// tb/tb_mfifo_wr_arbiter.sv - directed self-checking bench for mfifo_wr_arbiter
module tb_mfifo_wr_arbiter;
    import mfifo_arb_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req_valid;
    logic [3:0]       req_last;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ready;
    logic             full;
    logic             wren;
    logic [31:0]      wdata;
    logic             grant_valid;
    logic [1:0]       grant_id;

    int checks = 0;
    int errors = 0;

    mfifo_wr_arbiter #(
        .REQ_NUM    (4),
        .DATA_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid),
        .req_last_i    (req_last),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .full_i        (full),
        .wren_o        (wren),
        .wdata_o       (wdata),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic gv, input logic [1:0] gid,
                             input logic we, input logic [31:0] wd, input logic [3:0] rdy);
        check({tag, "_gv"},  32'(grant_valid), 32'(gv));
        check({tag, "_gid"}, 32'(grant_id),    32'(gid));
        check({tag, "_wren"}, 32'(wren),       32'(we));
        check({tag, "_wdata"}, wdata,          wd);
        check({tag, "_rdy"}, 32'(req_ready),   32'(rdy));
    endtask

    // Invariants sampled on the falling edge.
    logic       prev_lock = 1'b0;
    logic [1:0] prev_gid  = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            check("no_wren_when_full", 32'(wren && full), 32'd0);
            check("ready_onehot0", 32'($countones(req_ready) <= 1), 32'd1);
            if (dut.state == ST_LOCK && prev_lock) begin
                check("lock_gid_stable", 32'(grant_id), 32'(prev_gid));
            end
            prev_lock = (dut.state == ST_LOCK);
            prev_gid  = grant_id;
        end else begin
            prev_lock = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        full      = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i] = 32'hD0 + 32'(i);
        tick();
        tick();
        check_out("reset", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);

        // All valid single-word packets: grant walks 0,1,2,3,0.
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 1'b1,
                      32'hD0 + 32'(k % 4), 4'(1 << (k % 4)));
            tick();
        end
        req_valid = 4'b0000;
        #1;
        check_out("idle_ptr1", 1'b0, 2'd1, 1'b0, 32'h0, 4'b0000);

        // rr_ptr=1, only requester 3 valid.
        req_valid   = 4'b1000;
        req_data[3] = 32'h33;
        #1;
        check_out("wrap3", 1'b1, 2'd3, 1'b1, 32'h33, 4'b1000);
        tick();
        req_valid = 4'b0000;
        #1;
        check_out("idle_ptr0", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);

        // Requester 1 three-word packet with full stall; requester 2 waiting.
        req_valid   = 4'b0110;
        req_last    = 4'b0100;
        req_data[1] = 32'hA1;
        req_data[2] = 32'hB1;
        #1;
        check_out("pkt_a1", 1'b1, 2'd1, 1'b1, 32'hA1, 4'b0010);
        tick();
        req_data[1] = 32'hA2;
        full        = 1'b1;
        #1;
        check_out("full0", 1'b1, 2'd1, 1'b0, 32'h0, 4'b0000);
        tick();
        #1;
        check_out("full1", 1'b1, 2'd1, 1'b0, 32'h0, 4'b0000);
        tick();
        full = 1'b0;
        #1;
        check_out("pkt_a2", 1'b1, 2'd1, 1'b1, 32'hA2, 4'b0010);
        tick();
        req_data[1] = 32'hA3;
        req_last    = 4'b0110;
        #1;
        check_out("pkt_a3", 1'b1, 2'd1, 1'b1, 32'hA3, 4'b0010);
        tick();
        req_valid = 4'b0100;
        #1;
        check_out("pkt_b1", 1'b1, 2'd2, 1'b1, 32'hB1, 4'b0100);
        tick();

        // Requester 2 four-word packet, reset after two words.
        req_last    = 4'b0000;
        req_data[2] = 32'hC1;
        #1;
        check_out("c1", 1'b1, 2'd2, 1'b1, 32'hC1, 4'b0100);
        tick();
        req_data[2] = 32'hC2;
        #1;
        check_out("c2", 1'b1, 2'd2, 1'b1, 32'hC2, 4'b0100);
        tick();
        req_data[2] = 32'hC3;
        req_valid   = 4'b0101;
        #1;
        check_out("c3_locked", 1'b1, 2'd2, 1'b1, 32'hC3, 4'b0100);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);
        tick();
        req_last = 4'b0101;
        rst_n    = 1'b1;
        #1;
        check_out("post_rst", 1'b1, 2'd0, 1'b1, 32'hD0, 4'b0001);
        tick();
        #1;
        check_out("post_rst2", 1'b1, 2'd2, 1'b1, 32'hC3, 4'b0100);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
